mem_rw_arbiter: RTL and testbench
=================================

MEM_RW_ARBITER -- requirements
Module: mem_rw_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the main-memory read/write port (2..8).
REQ-002 Parameter INIT_CYCLES, default 256, cycles after reset during which the memory self-wipes and no grant is issued.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-high.
REQ-005 req_val_i  input  NREQ  per-requester request valid.
REQ-006 req_addr_i  input  NREQ x 8  per-requester word address.
REQ-007 req_wdata_i  input  NREQ x 16  per-requester write data.
REQ-008 req_wen_i  input  NREQ  per-requester write enable (1 = write, 0 = read).
REQ-009 req_lock_i  input  NREQ  per-requester lock (hold port after this beat).
REQ-010 req_rdy_o  output  NREQ  per-requester grant; beat accepted when req_val_i[i] && req_rdy_o[i].
REQ-011 rsp_val_o  output  NREQ  one-hot completion strobe, 1 cycle.
REQ-012 rsp_rdata_o  output  16  read data, shared by all requesters, qualified by rsp_val_o.
REQ-013 mem_addr_o, mem_wdata_o, mem_wen_o, mem_val_o  output  8/16/1/1  drive the memory rw port.
REQ-014 mem_rdy_i  input  1; mem_rdata_i  input  16  from the memory rw port.
REQ-015 busy_o  output  1  high while in INIT.

Function
REQ-016 FSM states: INIT, RUN, LOCKED; INIT -> RUN when the init counter reaches INIT_CYCLES-1.
REQ-017 In INIT: req_rdy_o = 0, mem_val_o = 0, busy_o = 1.
REQ-018 In RUN: round-robin winner = first i with req_val_i[i] set, searching from priority pointer upward modulo NREQ; req_rdy_o[winner] = mem_rdy_i, all other bits 0.
REQ-019 req_rdy_o is combinational from req_val_i, pointer, state and mem_rdy_i; it never depends on req_rdy_o.
REQ-020 mem_* outputs carry the winner's addr/wdata/wen with mem_val_o = req_val_i[winner] && mem_rdy_i; when there is no winner, mem_val_o = 0 and the other mem_* outputs are 0.
REQ-021 On an accepted beat from requester i, the pointer becomes (i+1) mod NREQ; with no accepted beat, the pointer holds.
REQ-022 Response latency is exactly 1 cycle: an accepted beat in cycle t gives rsp_val_o[i] = 1 in cycle t+1, for both reads and writes.
REQ-023 rsp_rdata_o = mem_rdata_i when the t+1 response is a read, 16'h0000 otherwise.
REQ-024 Back-to-back beats are allowed, giving one accepted beat per cycle at full throughput.
REQ-025 A write followed by a read of the same address in the next cycle returns the new data.
REQ-026 The arbiter never drops or duplicates a beat; at most one bit of rsp_val_o is set.

Reset
REQ-027 Reset (asynchronous, any cycle) forces: state = INIT, init counter = 0, pointer = 0, pending response cleared, lock owner cleared.
REQ-028 Output values under reset: req_rdy_o = 0, rsp_val_o = 0, rsp_rdata_o = 0, mem_val_o = 0, busy_o = 1.
REQ-029 A response in flight when reset asserts is discarded; it is not delivered after reset.

Configuration
REQ-030 Macro MEM_ARB_LOCK_EN defined: an accepted beat with req_lock_i[i] = 1 moves the FSM to LOCKED, owner = i.
REQ-031 In LOCKED, only the owner can be granted, and the pointer is frozen.
REQ-032 An accepted owner beat with req_lock_i = 0 returns the FSM to RUN, and the pointer becomes (owner+1) mod NREQ.
REQ-033 MEM_ARB_LOCK_EN undefined: the LOCKED state is not built and req_lock_i is ignored; the port stays present for uniform wiring.

Structure
REQ-034 Shared package global_pkg holds: arb_state_e (INIT/RUN/LOCKED), MEM_AW = 8, MEM_DW = 16, default INIT_CYCLES.
REQ-035 Sub-module rr_picker (combinational round-robin find-first-from-pointer, NREQ-wide) is instantiated once.

Verification
REQ-036 Scenario: reset, then hold req_val_i = 3'b111 -> no req_rdy_o for 256 cycles; first grant goes to requester 0 in cycle 256.
REQ-037 Scenario: all three requesters request continuously -> grants go 0,1,2,0,1,2, one per cycle, with no gap.
REQ-038 Scenario: requester 1 writes 16'hBEEF to 8'h10, and requester 2 reads 8'h10 in the next cycle -> rsp_val_o = 3'b100 one cycle later with rsp_rdata_o = 16'hBEEF.
REQ-039 Scenario (MEM_ARB_LOCK_EN): requester 0 issues a locked read and then an unlocked write, while requesters 1 and 2 request -> no grants to requesters 1 or 2 between the two beats; requester 1 is granted next.
REQ-040 Scenario: reset asserted in the cycle after an accepted read -> no rsp_val_o, and busy_o = 1 again.
REQ-041 Scenario: mem_rdy_i = 0 with pending requests -> req_rdy_o = 0, mem_val_o = 0, and the pointer is unchanged.

Source files
------------

// File: rtl/global_pkg.sv
// Shared types and constants for the main-memory read/write arbiter.
package global_pkg;

   localparam int MEM_AW          = 8;
   localparam int MEM_DW          = 16;
   localparam int INIT_CYCLES_DEF = 256;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      RUN    = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_rw_arbiter_if.sv
// Requester and memory-port bundle of mem_rw_arbiter; slave = arbiter side,
// master = requesters plus memory.
interface mem_rw_arbiter_if
   import global_pkg::*;
#(
   parameter int NREQ = 3
);

   logic [NREQ-1:0]              req_val_i;
   logic [NREQ-1:0][MEM_AW-1:0]  req_addr_i;
   logic [NREQ-1:0][MEM_DW-1:0]  req_wdata_i;
   logic [NREQ-1:0]              req_wen_i;
   logic [NREQ-1:0]              req_lock_i;
   logic [NREQ-1:0]              req_rdy_o;
   logic [NREQ-1:0]              rsp_val_o;
   logic [MEM_DW-1:0]            rsp_rdata_o;
   logic [MEM_AW-1:0]            mem_addr_o;
   logic [MEM_DW-1:0]            mem_wdata_o;
   logic                         mem_wen_o;
   logic                         mem_val_o;
   logic                         mem_rdy_i;
   logic [MEM_DW-1:0]            mem_rdata_i;

   modport slave (
      input  req_val_i, req_addr_i, req_wdata_i, req_wen_i, req_lock_i,
      input  mem_rdy_i, mem_rdata_i,
      output req_rdy_o, rsp_val_o, rsp_rdata_o,
      output mem_addr_o, mem_wdata_o, mem_wen_o, mem_val_o
   );

   modport master (
      output req_val_i, req_addr_i, req_wdata_i, req_wen_i, req_lock_i,
      output mem_rdy_i, mem_rdata_i,
      input  req_rdy_o, rsp_val_o, rsp_rdata_o,
      input  mem_addr_o, mem_wdata_o, mem_wen_o, mem_val_o
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_picker #(
   parameter  int NREQ = 3,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic            found_o,
   output logic [PW-1:0]   idx_o
);

   // Scan from farthest to nearest so the nearest hit is the one that sticks.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[PW'((int'(ptr_i) + k) % NREQ)]) begin
            found_o = 1'b1;
            idx_o   = PW'((int'(ptr_i) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter for the shared main-memory rw port with 1-cycle responses.
// Define MEM_ARB_LOCK_EN to build the LOCKED state (requester holds the port).
module mem_rw_arbiter
   import global_pkg::*;
#(
   parameter int NREQ        = 3,
   parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   mem_rw_arbiter_if.slave  bus,
   output logic             busy_o
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(INIT_CYCLES + 1);

   arb_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] rsp_val_q, rsp_val_d;
   logic            rsp_rd_q, rsp_rd_d;
   logic            busy_q, busy_d;

   logic            pick_found;
   logic [PW-1:0]   pick_idx;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic            accept;

`ifdef MEM_ARB_LOCK_EN
   logic [PW-1:0]   owner_q, owner_d;
`else
   logic            unused_lock;
   assign unused_lock = ^bus.req_lock_i;
`endif

   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
      return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
   endfunction

   rr_picker #(.NREQ(NREQ)) u_rr_picker (
      .req_i   (bus.req_val_i),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      win_found = 1'b0;
      win_idx   = pick_idx;
      case (state_q)
         RUN: win_found = pick_found;
`ifdef MEM_ARB_LOCK_EN
         LOCKED: begin
            win_found = bus.req_val_i[owner_q];
            win_idx   = owner_q;
         end
`endif
         default: win_found = 1'b0;
      endcase
      accept = win_found && bus.mem_rdy_i;
   end

   // Grant follows the memory's ready so a stalled port never accepts a beat.
   always_comb begin
      bus.req_rdy_o = '0;
      if (win_found) bus.req_rdy_o[win_idx] = bus.mem_rdy_i;
      bus.mem_val_o   = accept;
      bus.mem_addr_o  = win_found ? bus.req_addr_i[win_idx]  : '0;
      bus.mem_wdata_o = win_found ? bus.req_wdata_i[win_idx] : '0;
      bus.mem_wen_o   = win_found ? bus.req_wen_i[win_idx]   : 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      rsp_val_d = '0;
      rsp_rd_d  = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      owner_d   = owner_q;
`endif
      if (accept) begin
         rsp_val_d[win_idx] = 1'b1;
         rsp_rd_d           = !bus.req_wen_i[win_idx];
      end
      case (state_q)
         INIT: begin
            if (cnt_q == CW'(INIT_CYCLES - 1)) state_d = RUN;
            else                               cnt_d   = cnt_q + 1'b1;
         end
         RUN: begin
            if (accept) begin
               ptr_d = ptr_after(win_idx);
`ifdef MEM_ARB_LOCK_EN
               if (bus.req_lock_i[win_idx]) begin
                  state_d = LOCKED;
                  owner_d = win_idx;
               end
`endif
            end
         end
`ifdef MEM_ARB_LOCK_EN
         LOCKED: begin
            if (accept && !bus.req_lock_i[owner_q]) begin
               state_d = RUN;
               ptr_d   = ptr_after(owner_q);
            end
         end
`endif
         default: state_d = INIT;
      endcase
      busy_d = (state_d == INIT);
   end

   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         ptr_q     <= '0;
         rsp_val_q <= '0;
         rsp_rd_q  <= 1'b0;
         busy_q    <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
         owner_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         rsp_val_q <= rsp_val_d;
         rsp_rd_q  <= rsp_rd_d;
         busy_q    <= busy_d;
`ifdef MEM_ARB_LOCK_EN
         owner_q   <= owner_d;
`endif
      end
   end

   // Read data is taken straight from the memory in the response cycle.
   assign bus.rsp_val_o   = rsp_val_q;
   assign bus.rsp_rdata_o = rsp_rd_q ? bus.mem_rdata_i : '0;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Self-checking bench for mem_rw_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model (honours MEM_ARB_LOCK_EN).
module tb_mem_rw_arbiter;
   import global_pkg::*;

   localparam int NREQ  = 3;
   localparam int INITC = 256;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic chk_en = 1'b0;
   int   tests  = 0;
   int   fails  = 0;
   int   n;

   mem_rw_arbiter_if #(.NREQ(NREQ)) bus();

   mem_rw_arbiter #(.NREQ(NREQ), .INIT_CYCLES(INITC)) dut (
      .clk_i  (clk),
      .rst_ni (rst),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   // Environment: synchronous memory, wiped on reset.
   logic [15:0] ram [256];
   logic [15:0] rdata_q;
   assign bus.mem_rdata_i = rdata_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'h0;
         rdata_q <= 16'h0;
      end else begin
         if (bus.mem_val_o && bus.mem_wen_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
         rdata_q <= ram[bus.mem_addr_o];
      end
   end

   // Behavioural model
   int              m_cyc;
   int              m_ptr;
   int              m_owner;
   int              mw;
   logic [NREQ-1:0] m_rsp_val;
   logic [15:0]     m_rsp_data;
   logic [15:0]     shadow [256];

   function automatic int m_winner();
      int w;
      w = -1;
      if (rst || m_cyc < INITC) return -1;
      if (m_owner >= 0) return bus.req_val_i[m_owner] ? m_owner : -1;
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && bus.req_val_i[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      return w;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc = 0; m_ptr = 0; m_owner = -1;
         m_rsp_val = '0; m_rsp_data = '0;
         for (int i = 0; i < 256; i++) shadow[i] = 16'h0;
      end else begin
         mw = m_winner();
         m_rsp_val = '0;
         m_rsp_data = '0;
         if (mw >= 0 && bus.mem_rdy_i) begin
            m_rsp_val[mw] = 1'b1;
            if (bus.req_wen_i[mw]) shadow[bus.req_addr_i[mw]] = bus.req_wdata_i[mw];
            else                   m_rsp_data = shadow[bus.req_addr_i[mw]];
`ifdef MEM_ARB_LOCK_EN
            if (m_owner >= 0) begin
               if (!bus.req_lock_i[mw]) begin
                  m_owner = -1;
                  m_ptr = (mw + 1) % NREQ;
               end
            end else begin
               m_ptr = (mw + 1) % NREQ;
               if (bus.req_lock_i[mw]) m_owner = mw;
            end
`else
            m_ptr = (mw + 1) % NREQ;
`endif
         end
         if (m_cyc < INITC) m_cyc++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   int              cw;
   logic [NREQ-1:0] e_rdy;
   logic            e_mval, e_wen;
   logic [7:0]      e_addr;
   logic [15:0]     e_wd;

   always @(negedge clk) begin
      if (chk_en) begin
         cw = m_winner();
         e_rdy = '0; e_mval = 1'b0; e_addr = '0; e_wd = '0; e_wen = 1'b0;
         if (cw >= 0) begin
            e_rdy[cw] = bus.mem_rdy_i;
            e_mval    = bus.mem_rdy_i;
            e_addr    = bus.req_addr_i[cw];
            e_wd      = bus.req_wdata_i[cw];
            e_wen     = bus.req_wen_i[cw];
         end
         check("m_req_rdy",   32'(bus.req_rdy_o),   32'(e_rdy));
         check("m_mem_val",   32'(bus.mem_val_o),   32'(e_mval));
         check("m_mem_addr",  32'(bus.mem_addr_o),  32'(e_addr));
         check("m_mem_wdata", 32'(bus.mem_wdata_o), 32'(e_wd));
         check("m_mem_wen",   32'(bus.mem_wen_o),   32'(e_wen));
         check("m_rsp_val",   32'(bus.rsp_val_o),   32'(m_rsp_val));
         check("m_rsp_rdata", 32'(bus.rsp_rdata_o), 32'(m_rsp_data));
         check("m_busy",      32'(busy),            32'(rst || m_cyc < INITC));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_val_i   = '0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      bus.req_wen_i   = '0;
      bus.req_lock_i  = '0;
   endtask

   logic [2:0] rr_seq [5];

   initial begin
      rr_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst = 1'b1;
      idle_inputs();
      bus.mem_rdy_i = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_busy",      32'(busy), 32'h1);
      check("rst_req_rdy",   32'(bus.req_rdy_o), 32'h0);
      check("rst_rsp_val",   32'(bus.rsp_val_o), 32'h0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata_o), 32'h0);
      check("rst_mem_val",   32'(bus.mem_val_o), 32'h0);
      chk_en = 1'b1;

      // Init window with all requesters waiting, then continuous round robin
      bus.req_val_i = 3'b111;
      rst = 1'b0;
      n = 0;
      while (n < 400 && bus.req_rdy_o == '0) begin
         @(negedge clk);
         n++;
      end
      check("init_latency", n, 256);
      check("first_grant", 32'(bus.req_rdy_o), 32'h1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_grant", 32'(bus.req_rdy_o), 32'(rr_seq[i]));
      end

      // Write then read-after-write of the same address from another requester
      step();
      idle_inputs();
      bus.req_val_i = 3'b010;
      bus.req_wen_i[1] = 1'b1;
      bus.req_addr_i[1] = 8'h10;
      bus.req_wdata_i[1] = 16'hBEEF;
      @(negedge clk);
      check("raw_wr_grant", 32'(bus.req_rdy_o), 32'h2);
      step();
      idle_inputs();
      bus.req_val_i = 3'b100;
      bus.req_addr_i[2] = 8'h10;
      @(negedge clk);
      check("raw_rd_grant", 32'(bus.req_rdy_o), 32'h4);
      check("raw_wr_rsp", 32'(bus.rsp_val_o), 32'h2);
      check("raw_wr_rdata", 32'(bus.rsp_rdata_o), 32'h0);
      step();
      idle_inputs();
      @(negedge clk);
      check("raw_rd_rsp", 32'(bus.rsp_val_o), 32'h4);
      check("raw_rd_rdata", 32'(bus.rsp_rdata_o), 32'hBEEF);

      // Memory stall: no grant, pointer holds
      step();
      bus.req_val_i = 3'b110;
      bus.mem_rdy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_rdy", 32'(bus.req_rdy_o), 32'h0);
         check("stall_mem_val", 32'(bus.mem_val_o), 32'h0);
         if (i < 2) step();
      end
      step();
      bus.mem_rdy_i = 1'b1;
      @(negedge clk);
      check("stall_resume_grant", 32'(bus.req_rdy_o), 32'h2);
      step();
      idle_inputs();

      // Reset right after an accepted read discards the response
      step();
      bus.req_val_i = 3'b001;
      bus.req_addr_i[0] = 8'h10;
      @(negedge clk);
      check("rstrd_grant", 32'(bus.req_rdy_o), 32'h1);
      step();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      check("rstrd_rsp_val", 32'(bus.rsp_val_o), 32'h0);
      check("rstrd_busy", 32'(busy), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstrd_no_late_rsp", 32'(bus.rsp_val_o), 32'h0);
      n = 1;
      while (n < 400 && busy !== 1'b0) begin
         @(negedge clk);
         n++;
      end
      check("reinit_latency", n, 256);

      // Locked read then unlocked write by requester 0 while 1 and 2 wait
      step();
      bus.req_val_i = 3'b111;
      bus.req_addr_i = {8'h20, 8'h21, 8'h22};
      bus.req_lock_i = 3'b001;
      @(negedge clk);
      check("lock_first", 32'(bus.req_rdy_o), 32'h1);
      step();
      bus.req_lock_i = 3'b000;
      bus.req_wen_i[0] = 1'b1;
      bus.req_wdata_i[0] = 16'h1234;
      @(negedge clk);
`ifdef MEM_ARB_LOCK_EN
      check("lock_second", 32'(bus.req_rdy_o), 32'h1);
`else
      check("lock_second", 32'(bus.req_rdy_o), 32'h2);
`endif
      step();
      @(negedge clk);
`ifdef MEM_ARB_LOCK_EN
      check("lock_release", 32'(bus.req_rdy_o), 32'h2);
`else
      check("lock_release", 32'(bus.req_rdy_o), 32'h4);
`endif

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.req_val_i = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            bus.req_addr_i[i]  = 8'($urandom_range(0, 7));
            bus.req_wdata_i[i] = 16'($urandom);
            bus.req_wen_i[i]   = 1'($urandom);
            bus.req_lock_i[i]  = ($urandom_range(0, 7) == 0);
         end
         bus.mem_rdy_i = ($urandom_range(0, 3) != 0);
      end
      step();
      idle_inputs();
      bus.mem_rdy_i = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
